frame_gen: RTL and testbench

Synthesizable, parametrised frame generator for the switch core ingress. It emits frames on the `sof`/`dv`/`din` byte stream that `switch_top` consumes: header byte `{len[11:8], portmap}`, then `len[7:0]`, then payload, padded up to a multiple of 2^PAD_LOG2 bytes. Beyond single frames it provides burst count, programmable inter-frame gap, per-frame length sweep, selectable payload modes and graceful stop. It is used for on-chip self-test and as the bench stimulus source.

---
 rtl/frame_gen_pkg.sv | 36 +++
 rtl/frame_gen_if.sv | 40 ++++
 rtl/frame_gen_lfsr.sv | 25 ++
 rtl/frame_gen.sv | 180 ++++++++++++++++++
 tb/tb_frame_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_gen_pkg.sv
// Shared definitions for the frame generator.
// Contents:
//   - FSM state encoding
//   - payload mode encodings
//   - LFSR tap mask and step function
//   - header byte positions
package frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAY,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    MODE_INC     = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_ZPAD    = 2'd2,
    MODE_INC_ALT = 2'd3
  } mode_t;

  // x^8 + x^6 + x^5 + x^4 + 1 on a shift-left register: taps at bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Byte positions within a frame.
  localparam int HDR_LEN_HI_POS = 0;
  localparam int HDR_LEN_LO_POS = HDR_LEN_HI_POS + 1;
  localparam int PAY_FIRST_POS  = HDR_LEN_LO_POS + 1;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/frame_gen_if.sv
// Control and byte-stream bundle of the frame generator.
// Ports carried:
//   start, stop                 burst control pulses
//   cfg_len, cfg_len_inc        first length and per-frame increment
//   cfg_portmap, cfg_count      destination map and frames per burst
//   cfg_gap, cfg_mode           inter-frame gap and payload mode
//   sof, dv, dout               generated byte stream
//   busy, done, err, frm_cnt    status
// Modports: master = generator side, slave = controller/consumer side.
interface frame_gen_if #(
  parameter int LEN_W = 12,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [LEN_W-1:0] cfg_len;
  logic [LEN_W-1:0] cfg_len_inc;
  logic [3:0]       cfg_portmap;
  logic [CNT_W-1:0] cfg_count;
  logic [GAP_W-1:0] cfg_gap;
  logic [1:0]       cfg_mode;
  logic             sof;
  logic             dv;
  logic [7:0]       dout;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] frm_cnt;

  modport master (
    input  start, stop, cfg_len, cfg_len_inc, cfg_portmap, cfg_count, cfg_gap, cfg_mode,
    output sof, dv, dout, busy, done, err, frm_cnt
  );

  modport slave (
    output start, stop, cfg_len, cfg_len_inc, cfg_portmap, cfg_count, cfg_gap, cfg_mode,
    input  sof, dv, dout, busy, done, err, frm_cnt
  );
endinterface

// File: rtl/frame_gen_lfsr.sv
// 8-bit Fibonacci LFSR used for pseudo-random payload.
// Ports:
//   clk, rst  clock and asynchronous active-high reset (reloads SEED)
//   load      reload SEED (has priority over adv)
//   adv       step to the next value
//   q         current value
module frame_gen_lfsr
  import frame_gen_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= SEED;
    else if (load) q <= SEED;
    else if (adv)  q <= lfsr_next(q);
  end

endmodule

// File: rtl/frame_gen.sv
// Frame generator for the switch core ingress byte stream.
// Each frame: {len[11:8], portmap}, len[7:0], payload, padded with payload
// bytes up to a multiple of 2**PAD_LOG2. Supports bursts, gaps, length
// sweep, three payload modes and a stop that lets the current frame finish.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       frame_gen_if.master (config/control in, stream/status out)
// Header layout needs LEN_W = 12.
module frame_gen
  import frame_gen_pkg::*;
#(
  parameter int         LEN_W    = 12,
  parameter int         PAD_LOG2 = 6,
  parameter int         GAP_W    = 8,
  parameter int         CNT_W    = 16,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input logic          clk,
  input logic          rst,
  frame_gen_if.master  bus
);

  localparam logic [LEN_W:0] PAD_MASK  = (LEN_W+1)'((1 << PAD_LOG2) - 1);
  localparam logic [LEN_W:0] IDX_ONE   = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] IDX_FIRST = (LEN_W+1)'(PAY_FIRST_POS);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, inc_q, cur_len, len_sum, hdr_len;
  logic [3:0]       portmap_q, hdr_map;
  logic [CNT_W-1:0] count_q, frm_cnt;
  logic [GAP_W-1:0] gap_q, gap_cnt, gap_load;
  mode_t            mode_q;
  logic [LEN_W:0]   idx, idx_nxt, pad_len;
  logic             stop_pend, last_frame;
  logic             accept, reject, frame_end, burst_end;
  logic [7:0]       lfsr_q, pay_byte, dout_nxt;
  logic             sof_q, dv_q, busy_q, done_q, err_q;
  logic [7:0]       dout_q;

  // Byte index and padded length are one bit wider so 4095 rounds to 4096.
  assign pad_len    = ({1'b0, cur_len} + PAD_MASK) & ~PAD_MASK;
  assign len_sum    = cur_len + inc_q;
  assign gap_load   = (gap_q == '0) ? GAP_W'(1) : gap_q;
  assign last_frame = (count_q != '0) && ((frm_cnt + CNT_W'(1)) == count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    frame_end = 1'b0;
    burst_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.cfg_len != '0) begin
            accept    = 1'b1;
            state_nxt = ST_HDR0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_HDR0: state_nxt = ST_HDR1;
      ST_HDR1: state_nxt = ST_PAY;
      ST_PAY: begin
        if (idx == pad_len - IDX_ONE) begin
          frame_end = 1'b1;
          if (last_frame || stop_pend || bus.stop) begin
            burst_end = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop_pend || bus.stop) begin
          burst_end = 1'b1;
          state_nxt = ST_IDLE;
        end else if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = ST_HDR0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the byte computed here is
  // the one presented during the cycle after the edge. On start the header
  // comes straight from the config inputs, which are latched on that edge.
  always_comb begin
    idx_nxt = (state == ST_HDR1) ? IDX_FIRST : idx + IDX_ONE;
    hdr_len = accept ? bus.cfg_len : cur_len;
    hdr_map = accept ? bus.cfg_portmap : portmap_q;
    case (mode_q)
      MODE_LFSR: pay_byte = lfsr_q;
      MODE_ZPAD: pay_byte = (idx_nxt < {1'b0, cur_len}) ? idx_nxt[7:0] : 8'h00;
      default:   pay_byte = idx_nxt[7:0];
    endcase
    case (state_nxt)
      ST_HDR0: dout_nxt = {hdr_len[11:8], hdr_map};
      ST_HDR1: dout_nxt = cur_len[7:0];
      ST_PAY:  dout_nxt = pay_byte;
      default: dout_nxt = 8'h00;
    endcase
  end

  // LFSR holds the value of the next payload byte: reloaded on entry to
  // HDR0 so every frame repeats the same sequence.
  frame_gen_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (state_nxt == ST_HDR0),
    .adv  (state_nxt == ST_PAY),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      inc_q     <= '0;
      portmap_q <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      mode_q    <= MODE_INC;
      cur_len   <= '0;
      frm_cnt   <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
      sof_q     <= 1'b0;
      dv_q      <= 1'b0;
      dout_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        len_q     <= bus.cfg_len;
        inc_q     <= bus.cfg_len_inc;
        portmap_q <= bus.cfg_portmap;
        count_q   <= bus.cfg_count;
        gap_q     <= bus.cfg_gap;
        mode_q    <= mode_t'(bus.cfg_mode);
        cur_len   <= bus.cfg_len;
        frm_cnt   <= '0;
      end
      if (state_nxt == ST_PAY) idx <= idx_nxt;
      if (frame_end) begin
        frm_cnt <= frm_cnt + CNT_W'(1);
        // A sweep that wraps to zero restarts from the first length.
        cur_len <= (len_sum == '0) ? len_q : len_sum;
      end
      if (state_nxt == ST_GAP)
        gap_cnt <= (state == ST_GAP) ? gap_cnt - GAP_W'(1) : gap_load;
      // Stop seen while idle only counts when it arrives with an accepted start.
      stop_pend <= (state == ST_IDLE) ? (accept & bus.stop) : (stop_pend | bus.stop);
      sof_q  <= (state_nxt == ST_HDR0);
      dv_q   <= (state_nxt == ST_HDR0) || (state_nxt == ST_HDR1) || (state_nxt == ST_PAY);
      dout_q <= dout_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= burst_end;
      err_q  <= reject;
    end
  end

  assign bus.sof     = sof_q;
  assign bus.dv      = dv_q;
  assign bus.dout    = dout_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.frm_cnt = frm_cnt;

endmodule

// File: tb/tb_frame_gen.sv
// Directed self-checking bench for frame_gen.
module tb_frame_gen;
  localparam int LEN_W = 12, GAP_W = 8, CNT_W = 16, PAD_LOG2 = 6;
  localparam int PADB = 1 << PAD_LOG2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_gen_if #(.LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();

  frame_gen #(.LEN_W(LEN_W), .PAD_LOG2(PAD_LOG2), .GAP_W(GAP_W), .CNT_W(CNT_W),
              .SEED(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_n    = 0;
  logic [7:0] q_byte[$];
  logic       q_sof[$];
  int         q_cyc[$];
  int         done_cyc[$];
  logic [7:0] exp_q[$];
  logic       exp_sof[$];
  logic [7:0] lfsr_ref[0:4095];

  // Recorder: every dv byte with its sof flag and cycle number.
  always @(negedge clk) begin
    if (bus.dv === 1'b1) begin
      q_byte.push_back(bus.dout);
      q_sof.push_back(bus.sof);
      q_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
    if (bus.err === 1'b1) err_n++;
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input int len, input logic [3:0] map,
                                          input int mode, input int i);
    logic [11:0] l;
    l = len[11:0];
    if (i == 0) return {l[11:8], map};
    if (i == 1) return l[7:0];
    if (mode == 1) return lfsr_ref[i-2];
    if (mode == 2 && i >= len) return 8'h00;
    return i[7:0];
  endfunction

  task automatic add_frame(input int len, input logic [3:0] map, input int mode);
    int p;
    p = ((len + PADB - 1) / PADB) * PADB;
    for (int i = 0; i < p; i++) begin
      exp_q.push_back(exp_byte(len, map, mode, i));
      exp_sof.push_back(i == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_rec();
    q_byte.delete(); q_sof.delete(); q_cyc.delete(); done_cyc.delete();
    exp_q.delete(); exp_sof.delete();
    err_n = 0;
  endtask

  task automatic set_cfg(input int len, input int inc, input logic [3:0] map,
                         input int count, input int gap, input int mode);
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_len_inc = LEN_W'(inc);
    bus.cfg_portmap = map;
    bus.cfg_count   = CNT_W'(count);
    bus.cfg_gap     = GAP_W'(gap);
    bus.cfg_mode    = 2'(mode);
  endtask

  task automatic pulse_start(output int at);
    at = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin tick(); n++; end
    ok = (done_cyc.size() != 0);
    tick(); tick();
  endtask

  task automatic wait_bytes(input int count, input int budget, output bit ok);
    int n = 0;
    while (q_byte.size() < count && n < budget) begin tick(); n++; end
    ok = (q_byte.size() >= count);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0;
    set_cfg(0, 0, 4'h0, 0, 0, 0);
    repeat (3) tick();
    n_assert++;
    if ({bus.sof, bus.dv} !== 2'b00) begin n_fail++; $display("FAIL reset_sof_dv: got %b expected 00", {bus.sof, bus.dv}); end
    n_assert++;
    if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
    n_assert++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_assert++;
    if ({bus.done, bus.err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b expected 00", {bus.done, bus.err}); end
    n_assert++;
    if (bus.frm_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frm_cnt: got %0d expected 0", bus.frm_cnt); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_frame();
    int at; bit ok; int bad;
    clear_rec();
    set_cfg(126, 0, 4'hF, 1, 1, 0);
    add_frame(126, 4'hF, 0);
    pulse_start(at);
    wait_done(400, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got no done, expected one within 400 cycles"); end
    n_assert++;
    if (q_byte.size() != 128) begin n_fail++; $display("FAIL single_len: got %0d bytes expected 128", q_byte.size()); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_byte.size() || q_byte[i] !== exp_q[i] || q_sof[i] !== exp_sof[i]) begin bad = i; break; end
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL single_stream: byte %0d got %h expected %h", bad, (bad < q_byte.size()) ? q_byte[bad] : 8'h00, exp_q[bad]); end
    if (q_byte.size() == 128) begin
      n_assert++;
      if ({q_byte[0], q_byte[1], q_byte[127]} !== 24'h0F7E7F) begin n_fail++; $display("FAIL single_hdr_last: got %h expected 0f7e7f", {q_byte[0], q_byte[1], q_byte[127]}); end
      n_assert++;
      if (q_cyc[0] != at + 1) begin n_fail++; $display("FAIL single_latency: got sof at %0d expected %0d", q_cyc[0], at + 1); end
      n_assert++;
      if (q_cyc[127] - q_cyc[0] != 127) begin n_fail++; $display("FAIL single_contiguous: got span %0d expected 127", q_cyc[127] - q_cyc[0]); end
      n_assert++;
      if (done_cyc.size() != 1 || done_cyc[0] != q_cyc[127] + 1) begin n_fail++; $display("FAIL single_done_cycle: got %0d pulses expected 1 at %0d", done_cyc.size(), q_cyc[127] + 1); end
    end
    n_assert++;
    if (bus.frm_cnt !== 16'd1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_status: got frm_cnt %0d busy %b expected 1/0", bus.frm_cnt, bus.busy); end
  endtask

  task automatic test_zero_pad();
    int at; bit ok; int bad;
    clear_rec();
    set_cfg(129, 0, 4'h5, 1, 1, 2);
    add_frame(129, 4'h5, 2);
    pulse_start(at);
    wait_done(400, ok);
    n_assert++;
    if (q_byte.size() != 192) begin n_fail++; $display("FAIL zpad_len: got %0d bytes expected 192", q_byte.size()); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_byte.size() || q_byte[i] !== exp_q[i] || q_sof[i] !== exp_sof[i]) begin bad = i; break; end
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL zpad_stream: byte %0d got %h expected %h", bad, (bad < q_byte.size()) ? q_byte[bad] : 8'h00, exp_q[bad]); end
    if (q_byte.size() == 192) begin
      n_assert++;
      if ({q_byte[0], q_byte[1], q_byte[128], q_byte[129], q_byte[191]} !== 40'h0581800000) begin
        n_fail++; $display("FAIL zpad_points: got %h expected 0581800000", {q_byte[0], q_byte[1], q_byte[128], q_byte[129], q_byte[191]});
      end
    end
  endtask

  task automatic test_burst();
    int at; bit ok; int bad;
    clear_rec();
    set_cfg(64, 64, 4'hA, 3, 5, 0);
    add_frame(64, 4'hA, 0); add_frame(128, 4'hA, 0); add_frame(192, 4'hA, 0);
    pulse_start(at);
    // A second start with a different length while busy must be ignored.
    wait_bytes(10, 100, ok);
    bus.cfg_len = 12'd5;
    pulse_start(at);
    set_cfg(64, 64, 4'hA, 3, 5, 0);
    wait_done(800, ok);
    n_assert++;
    if (q_byte.size() != 384) begin n_fail++; $display("FAIL burst_len: got %0d bytes expected 384", q_byte.size()); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_byte.size() || q_byte[i] !== exp_q[i] || q_sof[i] !== exp_sof[i]) begin bad = i; break; end
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL burst_stream: byte %0d got %h expected %h", bad, (bad < q_byte.size()) ? q_byte[bad] : 8'h00, exp_q[bad]); end
    if (q_byte.size() == 384) begin
      n_assert++;
      if (q_cyc[64] - q_cyc[63] != 6 || q_cyc[192] - q_cyc[191] != 6) begin
        n_fail++; $display("FAIL burst_gap: got spacing %0d/%0d expected 6/6", q_cyc[64] - q_cyc[63], q_cyc[192] - q_cyc[191]);
      end
      n_assert++;
      if (done_cyc.size() != 1 || done_cyc[0] != q_cyc[383] + 1) begin n_fail++; $display("FAIL burst_done: got %0d pulses expected 1 at %0d", done_cyc.size(), q_cyc[383] + 1); end
    end
    n_assert++;
    if (bus.frm_cnt !== 16'd3) begin n_fail++; $display("FAIL burst_frm_cnt: got %0d expected 3", bus.frm_cnt); end
  endtask

  task automatic test_lfsr();
    int at; bit ok; int bad;
    clear_rec();
    set_cfg(64, 0, 4'h3, 2, 0, 1);
    add_frame(64, 4'h3, 1); add_frame(64, 4'h3, 1);
    pulse_start(at);
    wait_done(400, ok);
    n_assert++;
    if (q_byte.size() != 128) begin n_fail++; $display("FAIL lfsr_len: got %0d bytes expected 128", q_byte.size()); end
    if (q_byte.size() == 128) begin
      n_assert++;
      if ({q_byte[2], q_byte[3], q_byte[4], q_byte[5]} !== 32'hA54A952A) begin
        n_fail++; $display("FAIL lfsr_first: got %h expected a54a952a", {q_byte[2], q_byte[3], q_byte[4], q_byte[5]});
      end
      n_assert++;
      if (q_cyc[64] - q_cyc[63] != 2) begin n_fail++; $display("FAIL lfsr_gap0: got spacing %0d expected 2", q_cyc[64] - q_cyc[63]); end
    end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_byte.size() || q_byte[i] !== exp_q[i] || q_sof[i] !== exp_sof[i]) begin bad = i; break; end
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL lfsr_stream: byte %0d got %h expected %h", bad, (bad < q_byte.size()) ? q_byte[bad] : 8'h00, exp_q[bad]); end
  endtask

  task automatic test_stop();
    int at; bit ok; int c;
    // Stop during frame 2 of an endless burst.
    clear_rec();
    set_cfg(64, 0, 4'h1, 0, 3, 0);
    pulse_start(at);
    wait_bytes(74, 300, ok);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    wait_done(300, ok);
    repeat (20) tick();
    n_assert++;
    if (q_byte.size() != 128) begin n_fail++; $display("FAIL stop_frame_len: got %0d bytes expected 128", q_byte.size()); end
    n_assert++;
    if (done_cyc.size() != 1 || (q_byte.size() == 128 && done_cyc[0] != q_cyc[127] + 1)) begin
      n_fail++; $display("FAIL stop_frame_done: got %0d pulses expected 1 after last byte", done_cyc.size());
    end
    n_assert++;
    if (bus.frm_cnt !== 16'd2) begin n_fail++; $display("FAIL stop_frm_cnt: got %0d expected 2", bus.frm_cnt); end
    // Stop during the gap ends the burst at once.
    clear_rec();
    set_cfg(64, 0, 4'h1, 0, 20, 0);
    pulse_start(at);
    wait_bytes(64, 300, ok);
    tick(); tick();
    c = cyc;
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    repeat (30) tick();
    n_assert++;
    if (q_byte.size() != 64 || done_cyc.size() != 1 || done_cyc[0] != c + 1) begin
      n_fail++; $display("FAIL stop_gap: got %0d bytes, %0d done pulses expected 64 bytes and done at %0d", q_byte.size(), done_cyc.size(), c + 1);
    end
    // Start and stop together while idle: exactly one frame.
    clear_rec();
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    wait_done(300, ok);
    n_assert++;
    if (q_byte.size() != 64 || done_cyc.size() != 1) begin
      n_fail++; $display("FAIL start_stop_same: got %0d bytes %0d done expected 64/1", q_byte.size(), done_cyc.size());
    end
  endtask

  task automatic test_err();
    int at; int busy_seen = 0;
    clear_rec();
    set_cfg(0, 0, 4'h2, 1, 1, 0);
    pulse_start(at);
    repeat (5) begin
      if (bus.busy !== 1'b0) busy_seen++;
      tick();
    end
    n_assert++;
    if (err_n != 1) begin n_fail++; $display("FAIL err_pulse: got %0d err cycles expected 1", err_n); end
    n_assert++;
    if (busy_seen != 0 || q_byte.size() != 0) begin n_fail++; $display("FAIL err_idle: got busy %0d cycles, %0d bytes expected 0/0", busy_seen, q_byte.size()); end
  endtask

  task automatic test_max_len();
    int at; bit ok; int bad;
    clear_rec();
    set_cfg(4095, 0, 4'h1, 1, 1, 0);
    add_frame(4095, 4'h1, 0);
    pulse_start(at);
    wait_done(4300, ok);
    n_assert++;
    if (q_byte.size() != 4096) begin n_fail++; $display("FAIL max_len: got %0d bytes expected 4096", q_byte.size()); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_byte.size() || q_byte[i] !== exp_q[i] || q_sof[i] !== exp_sof[i]) begin bad = i; break; end
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL max_stream: byte %0d got %h expected %h", bad, (bad < q_byte.size()) ? q_byte[bad] : 8'h00, exp_q[bad]); end
    if (q_byte.size() == 4096) begin
      n_assert++;
      if ({q_byte[0], q_byte[1], q_byte[4095]} !== 24'hF1FFFF || q_cyc[4095] - q_cyc[0] != 4095) begin
        n_fail++; $display("FAIL max_points: got %h span %0d expected f1ffff span 4095", {q_byte[0], q_byte[1], q_byte[4095]}, q_cyc[4095] - q_cyc[0]);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    int at; bit ok; int n0;
    clear_rec();
    set_cfg(200, 0, 4'h7, 1, 1, 0);
    pulse_start(at);
    wait_bytes(100, 300, ok);
    rst = 1'b1;
    #1;
    n_assert++;
    if ({bus.dv, bus.sof, bus.dout, bus.busy} !== 11'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got dv %b sof %b dout %h busy %b expected all 0", bus.dv, bus.sof, bus.dout, bus.busy);
    end
    tick();
    rst = 1'b0;
    n0 = q_byte.size();
    repeat (10) tick();
    n_assert++;
    if (q_byte.size() != n0 || done_cyc.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle: got %0d new bytes %0d done busy %b expected 0/0/0", q_byte.size() - n0, done_cyc.size(), bus.busy);
    end
  endtask

  initial begin
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < 4096; i++) begin
      lfsr_ref[i] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    test_reset();
    test_single_frame();
    test_zero_pad();
    test_burst();
    test_lfsr();
    test_stop();
    test_err();
    test_max_len();
    test_rst_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
